// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle generator / checker pair.
package toggle_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int unsigned LOCK_CNT_DEF  = 4;
    localparam int unsigned ERR_LIMIT_DEF = 2;
    localparam int unsigned ERR_W_DEF     = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/toggle_checker.sv
// Receive-side monitor for a 0/1 square wave: locks on a run of good
// transitions, counts misses while locked, and drops lock on repeated misses.
module toggle_checker
    import toggle_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = LOCK_CNT_DEF,
    parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEF,
    parameter int unsigned ERR_W     = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(ERR_LIMIT + 1);
    localparam logic [GOOD_W-1:0] LOCK_V  = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] LIMIT_V = MISS_W'(ERR_LIMIT);

    state_t              r_state,       w_state_nxt;
    logic                r_din_q,       w_din_q_nxt;
    logic                r_have_sample, w_have_sample_nxt;
    logic [GOOD_W-1:0]   r_good_cnt,    w_good_cnt_nxt;
    logic [MISS_W-1:0]   r_miss_cnt,    w_miss_cnt_nxt;
    logic                r_locked,      w_locked_nxt;
    logic                r_err_pulse,   w_err_pulse_nxt;
    logic                w_trans;
    logic                w_err_inc;
    logic [GOOD_W-1:0]   w_good_inc;
    logic [MISS_W-1:0]   w_miss_inc;
    logic [ERR_W-1:0]    w_err_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= SEARCH;
            r_din_q       <= 1'b0;
            r_have_sample <= 1'b0;
            r_good_cnt    <= '0;
            r_miss_cnt    <= '0;
            r_locked      <= 1'b0;
            r_err_pulse   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_din_q       <= w_din_q_nxt;
            r_have_sample <= w_have_sample_nxt;
            r_good_cnt    <= w_good_cnt_nxt;
            r_miss_cnt    <= w_miss_cnt_nxt;
            r_locked      <= w_locked_nxt;
            r_err_pulse   <= w_err_pulse_nxt;
        end
    end

    // Next-state logic; the first enabled edge after reset only captures din.
    always_comb begin
        w_state_nxt       = r_state;
        w_din_q_nxt       = r_din_q;
        w_have_sample_nxt = r_have_sample;
        w_good_cnt_nxt    = r_good_cnt;
        w_miss_cnt_nxt    = r_miss_cnt;
        w_locked_nxt      = r_locked;
        w_err_pulse_nxt   = 1'b0;
        w_err_inc         = 1'b0;
        w_trans           = din ^ r_din_q;
        w_good_inc        = r_good_cnt + GOOD_W'(1);
        w_miss_inc        = r_miss_cnt + MISS_W'(1);

        if (en) begin
            w_din_q_nxt       = din;
            w_have_sample_nxt = 1'b1;
            if (r_have_sample) begin
                case (r_state)
                    SEARCH: begin
                        if (w_trans) begin
                            w_good_cnt_nxt = GOOD_W'(1);
                            if (GOOD_W'(1) == LOCK_V) begin
                                w_state_nxt  = LOCKED;
                                w_locked_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = LOCKING;
                            end
                        end
                    end
                    LOCKING: begin
                        if (w_trans) begin
                            w_good_cnt_nxt = w_good_inc;
                            if (w_good_inc == LOCK_V) begin
                                w_state_nxt  = LOCKED;
                                w_locked_nxt = 1'b1;
                            end
                        end else begin
                            w_state_nxt    = SEARCH;
                            w_good_cnt_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_trans) begin
                            w_err_pulse_nxt = 1'b1;
                            w_err_inc       = 1'b1;
                            w_miss_cnt_nxt  = MISS_W'(1);
                            if (MISS_W'(1) == LIMIT_V) begin
                                w_state_nxt    = SEARCH;
                                w_locked_nxt   = 1'b0;
                                w_good_cnt_nxt = '0;
                                w_miss_cnt_nxt = '0;
                            end else begin
                                w_state_nxt    = HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (w_trans) begin
                            w_state_nxt    = LOCKED;
                            w_miss_cnt_nxt = '0;
                        end else begin
                            w_err_pulse_nxt = 1'b1;
                            w_err_inc       = 1'b1;
                            w_miss_cnt_nxt  = w_miss_inc;
                            if (w_miss_inc == LIMIT_V) begin
                                w_state_nxt    = SEARCH;
                                w_locked_nxt   = 1'b0;
                                w_good_cnt_nxt = '0;
                                w_miss_cnt_nxt = '0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Clear acts regardless of en and wins over a same-edge increment.
    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_err_inc),
        .i_clr   (clr_err),
        .o_count (w_err_count)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = w_err_count;

endmodule

// File: tb/tb_toggle_checker.sv
// Bench for toggle_checker: two instances (ERR_W=8 and ERR_W=2) share stimulus;
// a behavioural model feeds a per-cycle scoreboard, scenario tasks add spot checks.
module tb_toggle_checker;

    localparam int LOCK_CNT  = 4;
    localparam int ERR_LIMIT = 2;

    typedef struct packed {
        logic       locked;
        logic       pulse;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       din;
    logic       clr_err;
    logic       locked8, pulse8;
    logic [7:0] cnt8;
    logic       locked2, pulse2;
    logic [1:0] cnt2;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];
    exp_t sb_e;

    // Model state
    logic       m_locked, m_pulse, m_prev, m_have;
    int         m_good, m_miss;
    logic [7:0] m_c8;
    logic [1:0] m_c2;
    logic       cur_din;

    toggle_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .ERR_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_err(clr_err),
        .locked(locked8), .err_pulse(pulse8), .err_count(cnt8)
    );

    toggle_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_err(clr_err),
        .locked(locked2), .err_pulse(pulse2), .err_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            checks++;
            if ({locked8, pulse8, cnt8, locked2, pulse2, cnt2} !==
                {sb_e.locked, sb_e.pulse, sb_e.c8, sb_e.locked, sb_e.pulse, sb_e.c2}) begin
                failures++;
                $display("FAIL scoreboard t=%0t got l8=%b p8=%b c8=%0d l2=%b p2=%b c2=%0d want l=%b p=%b c8=%0d c2=%0d",
                         $time, locked8, pulse8, cnt8, locked2, pulse2, cnt2,
                         sb_e.locked, sb_e.pulse, sb_e.c8, sb_e.c2);
            end
        end
    end

    task automatic reset_model();
        m_locked = 1'b0; m_pulse = 1'b0; m_prev = 1'b0; m_have = 1'b0;
        m_good = 0; m_miss = 0; m_c8 = '0; m_c2 = '0;
    endtask

    // Drive one cycle at the falling edge, advance the model, queue its prediction.
    task automatic step(input logic d, input logic e, input logic c);
        exp_t x;
        logic t;
        @(negedge clk);
        din = d; en = e; clr_err = c; cur_din = d;
        m_pulse = 1'b0;
        if (e) begin
            if (m_have) begin
                t = (d != m_prev);
                if (!m_locked) begin
                    if (t) begin
                        m_good++;
                        if (m_good == LOCK_CNT) m_locked = 1'b1;
                    end else begin
                        m_good = 0;
                    end
                end else if (t) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1'b1;
                    if (m_c8 != 8'hff) m_c8++;
                    if (m_c2 != 2'd3)  m_c2++;
                    m_miss++;
                    if (m_miss == ERR_LIMIT) begin
                        m_locked = 1'b0; m_good = 0; m_miss = 0;
                    end
                end
            end
            m_prev = d; m_have = 1'b1;
        end
        if (c) begin
            m_c8 = '0; m_c2 = '0;
        end
        x = '{locked: m_locked, pulse: m_pulse, c8: m_c8, c2: m_c2};
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic tog(input logic c = 1'b0);
        step(~cur_din, 1'b1, c);
    endtask

    task automatic miss(input logic c = 1'b0);
        step(cur_din, 1'b1, c);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; din = 1'b0; clr_err = 1'b0; cur_din = 1'b1;
        reset_model();
        #1 rst = 1'b0;
        #2;
        checks++;
        if ({locked8, pulse8, cnt8} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got l=%b p=%b c=%0d want 0/0/0", locked8, pulse8, cnt8);
        end
        checks++;
        if ({locked2, pulse2, cnt2} !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs_w2 got l=%b p=%b c=%0d want 0/0/0", locked2, pulse2, cnt2);
        end
    endtask

    task automatic test_lock();
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tog();
            if (i == 4) begin
                checks++;
                if (locked8 !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_early got locked=%b want 0 after edge 4", locked8);
                end
            end
        end
        checks++;
        if (locked8 !== 1'b1 || pulse8 !== 1'b0 || cnt8 !== 8'd0) begin
            failures++;
            $display("FAIL lock_edge5 got l=%b p=%b c=%0d want 1/0/0", locked8, pulse8, cnt8);
        end
        repeat (3) tog();
    endtask

    task automatic test_single_miss();
        miss();
        checks++;
        if (pulse8 !== 1'b1 || cnt8 !== 8'd1 || locked8 !== 1'b1) begin
            failures++;
            $display("FAIL single_miss got p=%b c=%0d l=%b want 1/1/1", pulse8, cnt8, locked8);
        end
        tog();
        checks++;
        if (pulse8 !== 1'b0 || cnt8 !== 8'd1 || locked8 !== 1'b1) begin
            failures++;
            $display("FAIL single_miss_after got p=%b c=%0d l=%b want 0/1/1", pulse8, cnt8, locked8);
        end
        repeat (2) tog();
    endtask

    task automatic test_double_miss();
        miss();
        checks++;
        if (locked8 !== 1'b1 || cnt8 !== 8'd2 || pulse8 !== 1'b1) begin
            failures++;
            $display("FAIL miss1 got l=%b c=%0d p=%b want 1/2/1", locked8, cnt8, pulse8);
        end
        miss();
        checks++;
        if (locked8 !== 1'b0 || cnt8 !== 8'd3 || pulse8 !== 1'b1) begin
            failures++;
            $display("FAIL miss2_unlock got l=%b c=%0d p=%b want 0/3/1", locked8, cnt8, pulse8);
        end
        miss();
        checks++;
        if (locked8 !== 1'b0 || cnt8 !== 8'd3 || pulse8 !== 1'b0) begin
            failures++;
            $display("FAIL miss3_uncounted got l=%b c=%0d p=%b want 0/3/0", locked8, cnt8, pulse8);
        end
        repeat (3) tog();
        checks++;
        if (locked8 !== 1'b0) begin
            failures++;
            $display("FAIL relock_early got locked=%b want 0", locked8);
        end
        tog();
        checks++;
        if (locked8 !== 1'b1) begin
            failures++;
            $display("FAIL relock got locked=%b want 1", locked8);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] want2;
        tog(1'b1);
        checks++;
        if (cnt8 !== 8'd0 || cnt2 !== 2'd0) begin
            failures++;
            $display("FAIL clr got c8=%0d c2=%0d want 0/0", cnt8, cnt2);
        end
        for (int k = 1; k <= 5; k++) begin
            miss();
            want2 = (k < 3) ? 2'(k) : 2'd3;
            checks++;
            if (cnt2 !== want2 || cnt8 !== 8'(k)) begin
                failures++;
                $display("FAIL saturate k=%0d got c2=%0d c8=%0d want %0d/%0d", k, cnt2, cnt8, want2, k);
            end
            tog();
        end
    endtask

    task automatic test_clr_collision();
        miss(1'b1);
        checks++;
        if (cnt8 !== 8'd0 || pulse8 !== 1'b1 || locked8 !== 1'b1) begin
            failures++;
            $display("FAIL clr_collision got c=%0d p=%b l=%b want 0/1/1", cnt8, pulse8, locked8);
        end
        tog();
        for (int i = 0; i < 3; i++) begin
            step(cur_din, 1'b0, 1'b0);
            checks++;
            if (locked8 !== 1'b1 || pulse8 !== 1'b0 || cnt8 !== 8'd0) begin
                failures++;
                $display("FAIL en_freeze i=%0d got l=%b p=%b c=%0d want 1/0/0", i, locked8, pulse8, cnt8);
            end
        end
        tog();
        checks++;
        if (locked8 !== 1'b1 || pulse8 !== 1'b0) begin
            failures++;
            $display("FAIL resume got l=%b p=%b want 1/0", locked8, pulse8);
        end
        miss();
        step(cur_din, 1'b0, 1'b1);
        checks++;
        if (cnt8 !== 8'd0 || pulse8 !== 1'b0) begin
            failures++;
            $display("FAIL clr_no_en got c=%0d p=%b want 0/0", cnt8, pulse8);
        end
        tog();
    endtask

    task automatic test_async_reset();
        repeat (3) tog();
        #1;
        rst = 1'b0;
        en  = 1'b0;
        reset_model();
        #1;
        checks++;
        if ({locked8, pulse8, cnt8} !== 10'd0 || {locked2, pulse2, cnt2} !== 4'd0) begin
            failures++;
            $display("FAIL async_reset got l=%b p=%b c=%0d want 0/0/0", locked8, pulse8, cnt8);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tog();
            if (i == 4) begin
                checks++;
                if (locked8 !== 1'b0) begin
                    failures++;
                    $display("FAIL post_reset_early got locked=%b want 0", locked8);
                end
            end
        end
        checks++;
        if (locked8 !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_lock got locked=%b want 1", locked8);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_miss();
        test_double_miss();
        test_saturate();
        test_clr_collision();
        test_async_reset();
        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_checker.md
Name: toggle_checker

Overview:
- Receive-side monitor for the alternating 0/1 square-wave output of the team's two-state toggle generator.
- Samples `din` once per clock and confirms it inverts every cycle. Declares lock after a run of good transitions, counts and flags missed transitions while locked, and drops lock after consecutive misses.
- Sits next to any toggle-generator instance as a link or health checker.

Parameters:
- LOCK_CNT, 4: consecutive valid transitions needed to assert `locked` (>=1).
- ERR_LIMIT, 2: consecutive missed transitions while locked that drop lock (>=1).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  sample enable; 0 freezes all state.
- din  input  1  toggling signal under check.
- clr_err  input  1  synchronous clear of `err_count`.
- locked  output  1  registered; 1 while the pattern is tracked.
- err_pulse  output  1  registered; one-cycle pulse per counted miss.
- err_count  output  ERR_W  registered; saturating count of misses while locked.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: `locked`=0, `err_pulse`=0, `err_count`=0.
  - Internal: state=SEARCH, `din_q`=0, `have_sample`=0, `good_cnt`=0, `miss_cnt`=0.
  - Takes effect immediately, without a clock edge, from any state.
- First enabled edge after reset: capture `din` into `din_q`, set `have_sample`. No comparison is made on this edge.
- Each later enabled edge:
  - transition = (din != din_q).
  - `din_q` <= `din`.
- en=0: every register holds its value; `err_pulse` is forced to 0.
- States (shared encoding):
  - SEARCH:
    - transition -> LOCKING, `good_cnt`=1 (if LOCK_CNT==1, go directly to LOCKED).
    - No transition -> stay.
  - LOCKING:
    - transition -> `good_cnt`+1. When the count reaches LOCK_CNT -> LOCKED and `locked`<=1 on that same edge.
    - Miss -> SEARCH, `good_cnt`=0. The miss is not counted as an error.
  - LOCKED:
    - transition -> stay.
    - Miss -> counted error (see below), `miss_cnt`=1. Go to HOLD, or to SEARCH with `locked`<=0 if ERR_LIMIT==1.
  - HOLD (`locked` remains 1):
    - transition -> LOCKED, `miss_cnt`=0.
    - Miss -> counted error, `miss_cnt`+1. On reaching ERR_LIMIT -> SEARCH, `locked`<=0, `good_cnt`=0.
- Counted error, applied on the edge the miss is sampled:
  - `err_pulse`<=1 for exactly one cycle.
  - `err_count` increments and saturates at 2^ERR_W-1, with no wrap-around.
- Misses are counted only in LOCKED or HOLD, never in SEARCH or LOCKING.
- clr_err=1 sets `err_count`<=0 on that edge, independent of `en`.
  - If a counted miss occurs on the same edge, clear wins: count=0, but `err_pulse` still asserts.
- Latency: the `locked` rise is visible the cycle after the LOCK_CNT-th transition edge. With a generator toggling from reset, that is edge LOCK_CNT+1 after release.

Decomposition:
- Shared package `toggle_pkg`: state encoding constants (SEARCH, LOCKING, LOCKED, HOLD; 2 bits) and the default LOCK_CNT/ERR_LIMIT values, also usable by the generator bench.
- One natural sub-module: `sat_counter` (parameter width; inc, clr with clr priority; async active-low reset), used for `err_count`.
- `good_cnt` and `miss_cnt` stay inline, each sized clog2(parameter+1).

Test Plan (LOCK_CNT=4, ERR_LIMIT=2, ERR_W=8 unless stated):
1. Release reset, en=1, `din`=0,1,0,1,... from the first edge -> `locked` goes 1 after the 5th edge; `err_pulse` never asserts; `err_count`=0.
2. While locked, hold `din` for 1 extra cycle, then resume toggling -> `err_pulse` high for exactly 1 cycle, `err_count`=1, `locked` stays 1 throughout.
3. While locked, hold `din` constant for 3 cycles -> `err_count`=2 and `locked`=0 after the 2nd miss. The 3rd miss is not counted. After resuming, `locked` returns to 1 after 4 transitions.
4. ERR_W=2, repeat the single-miss pattern of scenario 2 five times -> `err_count` reads 1,2,3,3,3 (saturates at 3).
5. clr_err=1 on the same edge as a counted miss with `err_count`=5 -> `err_count`=0 and `err_pulse`=1. Toggle `en`=0 for 3 cycles with `din` frozen -> no errors and no state change.
6. Drive rst=0 mid-LOCKED, between clock edges -> `locked`, `err_pulse`, `err_count` read 0 immediately. After release, relock requires the full 5-edge sequence.
